// File: rtl/ccr_flag_unit_if.sv
// Execute-stage CCR bus: ALU commit, conditional-jump evaluation and interrupt save/restore requests.
// The master modport is the execute-stage driver; the slave modport is the flag unit.
interface ccr_flag_unit_if #(
  parameter int FLAG_W = 3
);
  logic              alu_flag_we;
  logic [FLAG_W-1:0] alu_flags_in;
  logic              jmp_valid;
  logic [1:0]        jmp_type;
  logic              save_req;
  logic              restore_req;
  logic [FLAG_W-1:0] flags_out;
  logic [FLAG_W-1:0] flags_fwd;
  logic              branch_taken;

  // Request semantics: every request (we/jmp_valid/save_req/restore_req) is a
  // single-cycle strobe that takes effect on the next rising edge with stall=0.
  // There is no ready; the unit always accepts, and a request made while stall=1
  // is dropped, so the driver must hold or re-issue it after the stall.
  modport master (
    output alu_flag_we, alu_flags_in, jmp_valid, jmp_type, save_req, restore_req,
    input  flags_out, flags_fwd, branch_taken
  );

  modport slave (
    input  alu_flag_we, alu_flags_in, jmp_valid, jmp_type, save_req, restore_req,
    output flags_out, flags_fwd, branch_taken
  );
endinterface

// File: rtl/ccr_flag_unit.sv
// Condition-code register with forwarding, conditional-jump flag clearing and
// a LIFO that saves/restores flags across nested interrupts.
module ccr_flag_unit #(
  parameter int FLAG_W     = 3,
  parameter int SAVE_DEPTH = 4,
  localparam int PTR_W     = $clog2(SAVE_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  ccr_flag_unit_if.slave      bus,
  output logic [CNT_W-1:0]    save_count,
  output logic                save_overflow,
  output logic                restore_underflow
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] merged;
  logic [FLAG_W-1:0] fwd;
  logic [FLAG_W-1:0] clr_mask;
  logic              sel_flag;
  logic              taken;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              unf_q;
  logic [FLAG_W-1:0] mem [SAVE_DEPTH];
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Jump condition is tested on the forwarded (post-ALU-write) value.
  always_comb begin
    merged   = bus.alu_flag_we ? bus.alu_flags_in : flags_q;
    sel_flag = 1'b0;
    clr_mask = '0;
    case (bus.jmp_type)
      2'b00: begin sel_flag = merged[0]; clr_mask[0] = 1'b1; end
      2'b01: begin sel_flag = merged[1]; clr_mask[1] = 1'b1; end
      2'b10: begin sel_flag = merged[2]; clr_mask[2] = 1'b1; end
      default: begin sel_flag = 1'b0; clr_mask = '0; end
    endcase
    taken = bus.jmp_valid && sel_flag && !stall;
    fwd   = taken ? (merged & ~clr_mask) : merged;
  end

  assign full   = (count_q == CNT_W'(SAVE_DEPTH));
  assign empty  = (count_q == '0);
  assign push   = !stall && bus.save_req && !bus.restore_req;
  assign pop    = !stall && bus.restore_req && !bus.save_req;
  assign wr_idx = count_q[PTR_W-1:0];
  assign rd_idx = count_q[PTR_W-1:0] - PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!stall) begin
      if (pop && !empty) begin
        flags_q <= mem[rd_idx];
        count_q <= count_q - CNT_W'(1);
      end else begin
        flags_q <= fwd;
      end
      if (push && !full) count_q <= count_q + CNT_W'(1);
      if (push && full)  ovf_q   <= 1'b1;
      if (pop && empty)  unf_q   <= 1'b1;
    end
  end

  // Storage is never read unless written since reset, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= fwd;
  end

  assign bus.flags_out     = flags_q;
  assign bus.flags_fwd     = fwd;
  assign bus.branch_taken  = taken;
  assign save_count        = count_q;
  assign save_overflow     = ovf_q;
  assign restore_underflow = unf_q;

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Directed bench for ccr_flag_unit: forwarding, jumps, LIFO save/restore, overflow/underflow, stall, async reset.
module tb_ccr_flag_unit;
  logic       clk;
  logic       rst;
  logic       stall;
  logic [2:0] save_count;
  logic       save_overflow;
  logic       restore_underflow;
  int         n_tests;
  int         n_fail;

  ccr_flag_unit_if #(.FLAG_W(3)) bus ();

  ccr_flag_unit #(.FLAG_W(3), .SAVE_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .bus               (bus),
    .save_count        (save_count),
    .save_overflow     (save_overflow),
    .restore_underflow (restore_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_flag_we  = 1'b0;
    bus.alu_flags_in = 3'b000;
    bus.jmp_valid    = 1'b0;
    bus.jmp_type     = 2'b00;
    bus.save_req     = 1'b0;
    bus.restore_req  = 1'b0;
    stall            = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [2:0] din, input logic jv,
                       input logic [1:0] jt, input logic sv, input logic rs);
    bus.alu_flag_we  = we;
    bus.alu_flags_in = din;
    bus.jmp_valid    = jv;
    bus.jmp_type     = jt;
    bus.save_req     = sv;
    bus.restore_req  = rs;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b1;
    #12;
    chk("rst_flags", int'(bus.flags_out), 0);
    chk("rst_count", int'(save_count), 0);
    chk("rst_ovf", int'(save_overflow), 0);
    chk("rst_unf", int'(restore_underflow), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Forwarding of an ALU write
    drive(1'b1, 3'b011, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("t1_fwd", int'(bus.flags_fwd), 3);
    chk("t1_out_before", int'(bus.flags_out), 0);
    tick();
    chk("t1_out_after", int'(bus.flags_out), 3);

    // JN not taken, then JZ taken and Z cleared
    drive(1'b1, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 1'b0);
    chk("t2_jn_taken", int'(bus.branch_taken), 0);
    chk("t2_jn_fwd", int'(bus.flags_fwd), 1);
    tick();
    chk("t2_jn_out", int'(bus.flags_out), 1);
    drive(1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0);
    chk("t2_jz_taken", int'(bus.branch_taken), 1);
    chk("t2_jz_fwd", int'(bus.flags_fwd), 0);
    tick();
    chk("t2_jz_out", int'(bus.flags_out), 0);

    // JC on forwarded C
    drive(1'b1, 3'b101, 1'b1, 2'b10, 1'b0, 1'b0);
    chk("t3_jc_taken", int'(bus.branch_taken), 1);
    chk("t3_jc_fwd", int'(bus.flags_fwd), 1);
    tick();
    chk("t3_jc_out", int'(bus.flags_out), 1);

    // Reserved jump type never taken, nothing cleared
    drive(1'b1, 3'b111, 1'b1, 2'b11, 1'b0, 1'b0);
    chk("t3_rsv_taken", int'(bus.branch_taken), 0);
    chk("t3_rsv_fwd", int'(bus.flags_fwd), 7);
    tick();
    chk("t3_rsv_out", int'(bus.flags_out), 7);

    // LIFO push 100, 010, 001
    drive(1'b1, 3'b100, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    chk("t4_push1_cnt", int'(save_count), 1);
    chk("t4_push1_out", int'(bus.flags_out), 4);
    drive(1'b1, 3'b010, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    chk("t4_push2_cnt", int'(save_count), 2);
    drive(1'b1, 3'b001, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    chk("t4_push3_cnt", int'(save_count), 3);
    drive(1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    chk("t4_write_out", int'(bus.flags_out), 7);

    // Pops; second pop carries an ALU write that restore must override
    drive(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk("t4_pop1_out", int'(bus.flags_out), 1);
    chk("t4_pop1_cnt", int'(save_count), 2);
    drive(1'b1, 3'b111, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk("t4_pop2_out", int'(bus.flags_out), 2);
    chk("t4_pop2_cnt", int'(save_count), 1);
    drive(1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 1'b1);
    chk("t4_pop3_taken", int'(bus.branch_taken), 1);
    chk("t4_pop3_fwd", int'(bus.flags_fwd), 0);
    tick();
    chk("t4_pop3_out", int'(bus.flags_out), 4);
    chk("t4_pop3_cnt", int'(save_count), 0);

    // Fill to SAVE_DEPTH, then overflow
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0);
      tick();
    end
    chk("t5_full_cnt", int'(save_count), 4);
    chk("t5_full_ovf", int'(save_overflow), 0);
    drive(1'b1, 3'b110, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    chk("t5_ovf", int'(save_overflow), 1);
    chk("t5_ovf_cnt", int'(save_count), 4);
    chk("t5_ovf_out", int'(bus.flags_out), 6);

    // Save and restore together: no-op on the LIFO, no error
    drive(1'b1, 3'b100, 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    chk("t5_both_cnt", int'(save_count), 4);
    chk("t5_both_unf", int'(restore_underflow), 0);
    chk("t5_both_out", int'(bus.flags_out), 4);

    // Stall freezes everything and suppresses branch_taken
    stall = 1'b1;
    drive(1'b1, 3'b011, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("t6_stall_taken", int'(bus.branch_taken), 0);
    tick();
    chk("t6_stall_out", int'(bus.flags_out), 4);
    chk("t6_stall_cnt", int'(save_count), 4);
    stall = 1'b0;

    // Pop twice, leaving two entries, then async reset mid-cycle
    drive(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    tick();
    chk("t6_two_cnt", int'(save_count), 2);
    chk("t6_two_out", int'(bus.flags_out), 4);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_arst_out", int'(bus.flags_out), 0);
    chk("t6_arst_cnt", int'(save_count), 0);
    chk("t6_arst_ovf", int'(save_overflow), 0);
    chk("t6_arst_unf", int'(restore_underflow), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Underflow after reset; flags stay put
    drive(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk("t5_unf", int'(restore_underflow), 1);
    chk("t5_unf_out", int'(bus.flags_out), 0);
    chk("t5_unf_cnt", int'(save_count), 0);

    // Fresh push/pop after reset returns the new value, not stale contents
    drive(1'b1, 3'b010, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'b101, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk("t6_fresh_out", int'(bus.flags_out), 2);
    chk("t6_fresh_unf", int'(restore_underflow), 1);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
